obu_header_parser: RTL and testbench

//  Byte-stream front end of the AV1 bitstream path. Parses each OBU header, the optional

---
 rtl/obu_header_parser_pkg.sv | 47 ++++
 rtl/obu_header_parser_if.sv | 23 ++
 rtl/obu_header_parser.sv | 170 +++++++++++++++++
 tb/tb_obu_header_parser.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obu_header_parser_pkg.sv
// Shared types for the OBU header parser: OBU type codes, latched header fields and
// parser state encoding.
package obu_header_parser_pkg;

    localparam int unsigned LebMaxBytesDef = 5;
    localparam int unsigned SizeWDef       = 32;

    typedef enum logic [3:0] {
        ObuReserved0     = 4'd0,
        ObuSeqHdr        = 4'd1,
        ObuTd            = 4'd2,
        ObuFrameHdr      = 4'd3,
        ObuTileGroup     = 4'd4,
        ObuMetadata      = 4'd5,
        ObuFrame         = 4'd6,
        ObuRedundantFh   = 4'd7,
        ObuTileList      = 4'd8,
        ObuPadding       = 4'd15
    } obu_type_e;

    // obu_type stays raw: reserved codes must pass through unchanged.
    typedef struct packed {
        logic [3:0] obu_type;
        logic       has_ext;
        logic [2:0] temporal_id;
        logic [1:0] spatial_id;
    } obu_hdr_t;

    typedef enum logic [2:0] {
        StHdr,
        StExt,
        StSize,
        StPayload,
        StErr
    } parser_state_e;

    // Takes header bits [6:2]; extension ids start cleared.
    function automatic obu_hdr_t decode_hdr(input logic [4:0] hb);
        obu_hdr_t h;
        h.obu_type    = hb[4:1];
        h.has_ext     = hb[0];
        h.temporal_id = '0;
        h.spatial_id  = '0;
        return h;
    endfunction

endpackage

// File: rtl/obu_header_parser_if.sv
// Byte-stream handshake bundle around the OBU header parser: input byte side and
// payload output side.
interface obu_header_parser_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/obu_header_parser.sv
// AV1 OBU header parser: decodes header, optional extension byte and LEB128 obu_size,
// then forwards exactly obu_size payload bytes with zero latency.
module obu_header_parser
    import obu_header_parser_pkg::*;
#(
    parameter int unsigned LEB_MAX_BYTES = LebMaxBytesDef,
    parameter int unsigned SIZE_W        = SizeWDef
) (
    input  logic              clk,
    input  logic              rst,
    obu_header_parser_if.slave bus,
    output logic              hdr_valid,
    output logic [3:0]        obu_type,
    output logic              has_ext,
    output logic [2:0]        temporal_id,
    output logic [1:0]        spatial_id,
    output logic [SIZE_W-1:0] obu_size,
    output logic              err
);

    localparam int unsigned AccW = 7 * LEB_MAX_BYTES;
    localparam int unsigned IdxW = (LEB_MAX_BYTES > 1) ? $clog2(LEB_MAX_BYTES) : 1;

    parser_state_e     state_q, state_d;
    obu_hdr_t          hdr_q, hdr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] rem_q, rem_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              hdr_valid_q, hdr_valid_d;

    logic              in_ready_c;
    logic              out_valid_c;
    logic [7:0]        out_data_c;
    logic              out_last_c;

    logic [31:0]       leb_shift;
    logic [AccW-1:0]   acc_new;
    logic [SIZE_W-1:0] new_size;
    logic              size_overflow;
    logic              leb_last_idx;

    // Incoming LEB128 group merged into the accumulator; overflow looks at the merged value.
    always_comb begin
        leb_shift     = 32'd7 * 32'(idx_q);
        acc_new       = acc_q | (AccW'(bus.in_data[6:0]) << leb_shift);
        new_size      = SIZE_W'(acc_new);
        size_overflow = (acc_new >> SIZE_W) != '0;
        leb_last_idx  = (idx_q == IdxW'(LEB_MAX_BYTES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHdr;
            hdr_q       <= '0;
            size_q      <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            hdr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            size_q      <= size_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        size_d      = size_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        hdr_valid_d = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        out_last_c  = 1'b0;

        unique case (state_q)
            StHdr: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    hdr_d = decode_hdr(bus.in_data[6:2]);
                    // Forbidden bit set or size field absent: stream cannot be framed.
                    if (bus.in_data[7] || !bus.in_data[1]) begin
                        state_d = StErr;
                    end else begin
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = bus.in_data[2] ? StExt : StSize;
                    end
                end
            end

            StExt: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    hdr_d.temporal_id = bus.in_data[7:5];
                    hdr_d.spatial_id  = bus.in_data[4:3];
                    acc_d             = '0;
                    idx_d             = '0;
                    state_d           = StSize;
                end
            end

            StSize: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_data[7]) begin
                        if (leb_last_idx) begin
                            state_d = StErr;
                        end else begin
                            acc_d = acc_new;
                            idx_d = idx_q + IdxW'(1);
                        end
                    end else if (size_overflow) begin
                        state_d = StErr;
                    end else begin
                        size_d      = new_size;
                        rem_d       = new_size;
                        acc_d       = '0;
                        hdr_valid_d = 1'b1;
                        state_d     = (new_size != '0) ? StPayload : StHdr;
                    end
                end
            end

            StPayload: begin
                in_ready_c  = bus.out_ready;
                out_valid_c = bus.in_valid;
                out_data_c  = bus.in_data;
                out_last_c  = (rem_q == SIZE_W'(1));
                if (bus.in_valid && bus.out_ready) begin
                    rem_d = rem_q - SIZE_W'(1);
                    if (rem_q == SIZE_W'(1)) begin
                        state_d = StHdr;
                    end
                end
            end

            StErr: begin
                state_d = StErr;
            end

            default: begin
                state_d = StErr;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign bus.out_last  = out_last_c;

    assign hdr_valid   = hdr_valid_q;
    assign obu_type    = hdr_q.obu_type;
    assign has_ext     = hdr_q.has_ext;
    assign temporal_id = hdr_q.temporal_id;
    assign spatial_id  = hdr_q.spatial_id;
    assign obu_size    = size_q;
    assign err         = (state_q == StErr);

endmodule

// File: tb/tb_obu_header_parser.sv
// Directed bench for obu_header_parser: scoreboarded headers and payload beats, plus
// error and mid-OBU reset scenarios.
module tb_obu_header_parser;
    import obu_header_parser_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        hdr_valid;
    logic [3:0]  obu_type;
    logic        has_ext;
    logic [2:0]  temporal_id;
    logic [1:0]  spatial_id;
    logic [31:0] obu_size;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_ready = 1'b0;

    logic [8:0]  pay_q[$];
    logic [41:0] hdr_q[$];

    always #5 clk = ~clk;

    obu_header_parser_if bus ();

    obu_header_parser #(
        .LEB_MAX_BYTES(5),
        .SIZE_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hdr_valid  (hdr_valid),
        .obu_type   (obu_type),
        .has_ext    (has_ext),
        .temporal_id(temporal_id),
        .spatial_id (spatial_id),
        .obu_size   (obu_size),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] hx(input logic [3:0] t, input logic e, input logic [2:0] tid,
                                       input logic [1:0] sid, input logic [31:0] sz);
        return {t, e, tid, sid, sz};
    endfunction

    // Holds the byte until in_ready is seen before a rising edge; returns at posedge+1.
    task automatic send(input logic [7:0] b);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_ready) bus.out_ready = 1'($urandom_range(1, 0));
    end

    // Scoreboard monitor: pops expectations as the DUT publishes headers and beats.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (pay_q.size() == 0) chk("spurious_beat", 64'(pay_q.size()), 64'd1);
                else chk("payload", {55'd0, bus.out_last, bus.out_data}, 64'(pay_q.pop_front()));
            end
            if (bus.out_valid) chk("in_ready_mirror", 64'(bus.in_ready), 64'(bus.out_ready));
            if (hdr_valid) begin
                if (hdr_q.size() == 0) chk("spurious_hdr", 64'(hdr_q.size()), 64'd1);
                else chk("header", 64'({obu_type, has_ext, temporal_id, spatial_id, obu_size}),
                         64'(hdr_q.pop_front()));
            end
        end
    end

    initial begin
        int c0;
        logic [7:0] b;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_obu_size", 64'(obu_size), 64'd0);
        chk("rst_obu_type", 64'(obu_type), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-size OBU, then a 3-byte OBU read straight after.
        hdr_q.push_back(hx(ObuTd, 1'b0, 3'd0, 2'd0, 32'd0));
        send(8'h12);
        send(8'h00);
        hdr_q.push_back(hx(ObuFrame, 1'b0, 3'd0, 2'd0, 32'd3));
        send(8'h32);
        send(8'h03);
        c0 = cyc;
        pay_q.push_back({1'b0, 8'hAA}); send(8'hAA);
        pay_q.push_back({1'b0, 8'hBB}); send(8'hBB);
        pay_q.push_back({1'b1, 8'hCC}); send(8'hCC);
        chk("consecutive_beats", 64'(cyc - c0), 64'd3);

        // Extension byte and two-byte LEB128 size, back to back with the previous OBU.
        hdr_q.push_back(hx(ObuFrame, 1'b1, 3'd2, 2'd1, 32'd128));
        send(8'h36);
        send(8'h48);
        send(8'h80);
        send(8'h01);
        for (int i = 0; i < 128; i++) begin
            b = 8'($urandom);
            pay_q.push_back({i == 127, b});
            send(b);
        end

        // Back-pressure: out_ready toggles randomly.
        hdr_q.push_back(hx(ObuTileGroup, 1'b0, 3'd0, 2'd0, 32'd20));
        send(8'h22);
        send(8'h14);
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            pay_q.push_back({i == 19, b});
            send(b);
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;

        // Five-byte LEB128 at the limit, terminating on the last allowed byte.
        hdr_q.push_back(hx(ObuTd, 1'b0, 3'd0, 2'd0, 32'd0));
        send(8'h12);
        repeat (4) send(8'h80);
        send(8'h00);
        idle(2);

        // Reset in the middle of a size-5 payload.
        hdr_q.push_back(hx(ObuMetadata, 1'b0, 3'd0, 2'd0, 32'd5));
        send(8'h2A);
        send(8'h05);
        pay_q.push_back({1'b0, 8'h11}); send(8'h11);
        pay_q.push_back({1'b0, 8'h22}); send(8'h22);
        pulse_rst();
        @(negedge clk);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_hdr_valid", 64'(hdr_valid), 64'd0);
        chk("midrst_size", 64'(obu_size), 64'd0);
        @(posedge clk);
        #1;
        hdr_q.push_back(hx(ObuTd, 1'b0, 3'd0, 2'd0, 32'd0));
        send(8'h12);
        send(8'h00);
        idle(2);
        @(negedge clk);
        chk("midrst_err", 64'(err), 64'd0);
        chk("drain_payload", 64'(pay_q.size()), 64'd0);
        chk("drain_hdr", 64'(hdr_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Forbidden bit: sticky error, input stalled even with data offered.
        send(8'h92);
        @(negedge clk);
        chk("forbidden_err", 64'(err), 64'd1);
        chk("forbidden_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.in_data = 8'h12;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_in_ready", 64'(bus.in_ready), 64'd0);
        chk("err_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        pulse_rst();
        send(8'h10);
        idle(1);
        @(negedge clk);
        chk("no_size_err", 64'(err), 64'd1);
        @(posedge clk);
        #1;

        pulse_rst();
        send(8'h12);
        repeat (4) send(8'hFF);
        send(8'h10);
        idle(1);
        @(negedge clk);
        chk("size_overflow_err", 64'(err), 64'd1);
        @(posedge clk);
        #1;

        pulse_rst();
        send(8'h12);
        repeat (5) send(8'h80);
        idle(1);
        @(negedge clk);
        chk("leb_too_long_err", 64'(err), 64'd1);

        repeat (3) @(posedge clk);
        chk("final_hdr_q", 64'(hdr_q.size()), 64'd0);
        chk("final_pay_q", 64'(pay_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
